// File: rtl/breakpoint_unit.sv
// PC breakpoint table with hit/continue/skip sequencing feeding the clock/halt controller.
// Optional saturating hit counter enabled by defining BREAKPOINT_HIT_COUNT_EN.
module breakpoint_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_BP     = 4,
    localparam int IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_breakpointEnableN,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_instrStart,
    input  logic                  i_ctrlInstrFinishedN,
    input  logic                  i_continue,
    input  logic                  i_bpWrEn,
    input  logic [IDX_W-1:0]      i_bpIdx,
    input  logic [ADDR_WIDTH-1:0] i_bpAddr,
    input  logic                  i_bpValid,
    output logic                  o_breakpointHitN,
    output logic [IDX_W-1:0]      o_hitIdx,
    output logic [7:0]            o_hitCount
);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        HIT   = 2'd1,
        SKIP  = 2'd2
    } bpState_e;

    bpState_e          stateReg;
    bpState_e          stateNext;
    logic              loadHit;
    logic [NUM_BP-1:0] matchVec;
    logic              anyMatch;
    logic [IDX_W-1:0]  winIdx;
    logic              hitNReg;
    logic [IDX_W-1:0]  hitIdxReg;

    // One register pair per entry; out-of-range indices decode to no entry and are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BP; gi++) begin : gen_entry
            localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);
            logic                  validReg;
            logic [ADDR_WIDTH-1:0] addrReg;

            always_ff @(posedge i_clk or negedge i_resetn) begin
                if (!i_resetn) begin
                    validReg <= 1'b0;
                    addrReg  <= '0;
                end else if (i_bpWrEn && (i_bpIdx == ENTRY_IDX)) begin
                    validReg <= i_bpValid;
                    addrReg  <= i_bpAddr;
                end
            end

            assign matchVec[gi] = validReg && (addrReg == i_pc);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        anyMatch = 1'b0;
        winIdx   = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (matchVec[k]) begin
                anyMatch = 1'b1;
                winIdx   = IDX_W'(k);
            end
        end
    end

    // SKIP behaves as ARMED in the cycle its instruction finishes, so back-to-back starts can hit.
    always_comb begin
        stateNext = stateReg;
        loadHit   = 1'b0;
        case (stateReg)
            HIT: begin
                if (i_breakpointEnableN) begin
                    stateNext = ARMED;
                end else if (i_continue) begin
                    stateNext = SKIP;
                end
            end
            default: begin
                if ((stateReg == ARMED) || !i_ctrlInstrFinishedN) begin
                    if (!i_breakpointEnableN && i_instrStart && anyMatch) begin
                        stateNext = HIT;
                        loadHit   = 1'b1;
                    end else begin
                        stateNext = ARMED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            stateReg  <= ARMED;
            hitNReg   <= 1'b1;
            hitIdxReg <= '0;
        end else begin
            stateReg <= stateNext;
            hitNReg  <= (stateNext != HIT);
            if (loadHit) begin
                hitIdxReg <= winIdx;
            end
        end
    end

    assign o_breakpointHitN = hitNReg;
    assign o_hitIdx         = hitIdxReg;

`ifdef BREAKPOINT_HIT_COUNT_EN
    logic [7:0] hitCountReg;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            hitCountReg <= '0;
        end else if (loadHit && (hitCountReg != 8'hFF)) begin
            hitCountReg <= hitCountReg + 8'd1;
        end
    end

    assign o_hitCount = hitCountReg;
`else
    assign o_hitCount = '0;
`endif

endmodule

// File: tb/tb_breakpoint_unit.sv
// Vector-table bench for breakpoint_unit with an expected-result queue and a hit-count model.
module tb_breakpoint_unit;

    localparam int AW = 16;
    localparam int NB = 4;
    localparam int IW = 2;
`ifdef BREAKPOINT_HIT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          enN;
    logic [AW-1:0] pc;
    logic          instrStart;
    logic          finN;
    logic          cont;
    logic          bpWrEn;
    logic [IW-1:0] bpIdx;
    logic [AW-1:0] bpAddr;
    logic          bpValid;
    logic          hitN;
    logic [IW-1:0] hitIdx;
    logic [7:0]    hitCount;

    always #5 clk = ~clk;

    breakpoint_unit #(.ADDR_WIDTH(AW), .NUM_BP(NB)) dut (
        .i_clk                (clk),
        .i_resetn             (resetn),
        .i_breakpointEnableN  (enN),
        .i_pc                 (pc),
        .i_instrStart         (instrStart),
        .i_ctrlInstrFinishedN (finN),
        .i_continue           (cont),
        .i_bpWrEn             (bpWrEn),
        .i_bpIdx              (bpIdx),
        .i_bpAddr             (bpAddr),
        .i_bpValid            (bpValid),
        .o_breakpointHitN     (hitN),
        .o_hitIdx             (hitIdx),
        .o_hitCount           (hitCount)
    );

    typedef struct {
        logic          wr;
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic          val;
        logic          enN;
        logic [AW-1:0] pc;
        logic          start;
        logic          finN;
        logic          cont;
        int            rep;
        logic          expHitN;
        logic [IW-1:0] expIdx;
    } vec_t;

    typedef struct {
        int            id;
        logic          hitN;
        logic [IW-1:0] idx;
        logic [7:0]    cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   modelCnt = 0;
    logic prevExpHitN = 1'b1;

    function automatic vec_t mk(logic wr, logic [IW-1:0] idx, logic [AW-1:0] addr, logic val,
                                logic en_n, logic [AW-1:0] p, logic st, logic fn, logic ct,
                                int rep, logic eh, logic [IW-1:0] ei);
        vec_t v;
        v.wr = wr; v.idx = idx; v.addr = addr; v.val = val;
        v.enN = en_n; v.pc = p; v.start = st; v.finN = fn; v.cont = ct;
        v.rep = rep; v.expHitN = eh; v.expIdx = ei;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, queue its expectation, compare just after the rising edge.
    task automatic step(input vec_t v, input int id);
        exp_t e;
        exp_t g;
        @(negedge clk);
        bpWrEn = v.wr; bpIdx = v.idx; bpAddr = v.addr; bpValid = v.val;
        enN = v.enN; pc = v.pc; instrStart = v.start; finN = v.finN; cont = v.cont;
        if (prevExpHitN && !v.expHitN && modelCnt < 255) modelCnt++;
        prevExpHitN = v.expHitN;
        e.id = id; e.hitN = v.expHitN; e.idx = v.expIdx;
        e.cnt = CNT_EN ? 8'(modelCnt) : 8'd0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard (vec %0d): queue empty", id);
        end else begin
            g = sbq.pop_front();
            check("hitN", g.id, {15'd0, hitN}, {15'd0, g.hitN});
            check("hitIdx", g.id, {14'd0, hitIdx}, {14'd0, g.idx});
            check("hitCount", g.id, {8'd0, hitCount}, {8'd0, g.cnt});
        end
    endtask

    initial begin
        vec_t v;
        resetn = 1'b0; enN = 1'b1; pc = '0; instrStart = 1'b0; finN = 1'b1; cont = 1'b0;
        bpWrEn = 1'b0; bpIdx = '0; bpAddr = '0; bpValid = 1'b0;

        //        wr idx addr     val enN pc       st fn ct rep eh ei
        vecs.push_back(mk(1, 0, 16'h0040, 1, 1, 16'h0000, 0, 1, 0, 1,  1, 0)); // 0 write idx0
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 1, 0, 1,  0, 0)); // 1 basic hit
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 1, 0, 20, 0, 0)); // 2 held 20 cycles
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 1, 1, 1,  1, 0)); // 3 continue
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 1, 0, 1,  1, 0)); // 4 start in SKIP
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 1, 0, 1,  1, 0)); // 5 idle
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 0, 0, 1,  1, 0)); // 6 finish
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 1, 0, 1,  0, 0)); // 7 re-hit
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 1, 1, 1,  1, 0)); // 8 continue
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 0, 0, 1,  0, 0)); // 9 finish+start hits
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 1, 1, 1,  1, 0)); // 10 continue
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 0, 0, 1,  1, 0)); // 11 finish
        vecs.push_back(mk(1, 1, 16'h0100, 1, 0, 16'h0000, 0, 1, 0, 1,  1, 0)); // 12 write idx1
        vecs.push_back(mk(1, 3, 16'h0100, 1, 0, 16'h0000, 0, 1, 0, 1,  1, 0)); // 13 write idx3
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1,  1, 0)); // 14 clear idx0
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 1, 0, 1,  0, 1)); // 15 priority idx1
        vecs.push_back(mk(1, 1, 16'h0000, 0, 0, 16'h0100, 1, 1, 0, 1,  0, 1)); // 16 clear idx1 in HIT
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 1, 1, 1,  1, 1)); // 17 continue
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 0, 0, 1,  1, 1)); // 18 finish
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 1, 0, 1,  0, 3)); // 19 hit idx3
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0100, 0, 1, 0, 1,  1, 3)); // 20 disable releases
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0100, 1, 1, 0, 1,  1, 3)); // 21 disabled start
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0100, 0, 1, 0, 3,  1, 3)); // 22 idle disabled
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 1, 0, 1,  0, 3)); // 23 hit idx3
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0100, 0, 1, 1, 1,  1, 3)); // 24 continue+disable
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 1, 0, 1,  0, 3)); // 25 ARMED, hits
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 1, 1, 1,  1, 3)); // 26 continue
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 1, 1, 1,  1, 3)); // 27 continue in SKIP
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 0, 0, 1,  1, 3)); // 28 finish
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 1, 1, 1,  1, 3)); // 29 continue in ARMED
        vecs.push_back(mk(1, 2, 16'h0200, 1, 0, 16'h0200, 1, 1, 0, 1,  1, 3)); // 30 write collision
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0200, 1, 1, 0, 1,  0, 2)); // 31 hit idx2

        #12;
        check("reset hitN", -1, {15'd0, hitN}, 16'd1);
        check("reset hitIdx", -1, {14'd0, hitIdx}, 16'd0);
        check("reset hitCount", -1, {8'd0, hitCount}, 16'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                step(vecs[i], i);
            end
        end

        // Asynchronous reset while halted must release at once and wipe the table.
        #2;
        resetn = 1'b0;
        #1;
        check("async reset hitN", 100, {15'd0, hitN}, 16'd1);
        check("async reset hitIdx", 100, {14'd0, hitIdx}, 16'd0);
        check("async reset hitCount", 100, {8'd0, hitCount}, 16'd0);
        modelCnt = 0;
        prevExpHitN = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        step(mk(0, 0, 16'h0000, 0, 0, 16'h0200, 1, 1, 0, 1, 1, 0), 101);
        step(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 1, 1, 0, 1, 1, 0), 102);
        step(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 1, 0, 1, 1, 0), 103);

        // Counter run: 300 hit/continue/finish rounds.
        step(mk(1, 0, 16'h0040, 1, 0, 16'h0000, 0, 1, 0, 1, 1, 0), 200);
        for (int n = 0; n < 300; n++) begin
            step(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 1, 1, 0, 1, 0, 0), 201);
            step(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 1, 1, 1, 1, 0), 202);
            step(mk(0, 0, 16'h0000, 0, 0, 16'h0040, 0, 0, 0, 1, 1, 0), 203);
        end
        check("hitCount final", 300, {8'd0, hitCount}, CNT_EN ? 16'd255 : 16'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/breakpoint_unit.md
Name: breakpoint_unit

Overview:
- Upstream neighbour of the clock/halt controller.
- Holds a small table of PC breakpoint addresses and compares each newly fetched PC against it.
- Drives the active-low breakpoint-hit line that the clock controller turns into a halt in run mode.
- Owns the hit/continue/skip sequencing, so a resumed program does not immediately re-trigger on the same PC.

Parameters:
- ADDR_WIDTH, 16, width of PC and breakpoint addresses.
- NUM_BP, 4, number of breakpoint entries (1..16).

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_resetn  in  1  asynchronous active-low reset.
- i_breakpointEnableN  in  1  0 = breakpoints enabled (from clock controller).
- i_pc  in  ADDR_WIDTH  PC of the instruction being started.
- i_instrStart  in  1  1-cycle pulse: i_pc is valid for a new instruction.
- i_ctrlInstrFinishedN  in  1  0 = current instruction completes this cycle.
- i_continue  in  1  1-cycle pulse: user resumes from a breakpoint (already synchronised upstream).
- i_bpWrEn  in  1  write strobe for the breakpoint table.
- i_bpIdx  in  $clog2(NUM_BP) (min 1)  entry to write.
- i_bpAddr  in  ADDR_WIDTH  address to store.
- i_bpValid  in  1  valid bit to store (0 clears the entry).
- o_breakpointHitN  out  1  0 = halted on breakpoint.
- o_hitIdx  out  $clog2(NUM_BP) (min 1)  index of the entry that caused the last hit.
- o_hitCount  out  8  saturating hit counter (see Optional Feature).

Behaviour:
- Reset (async, i_resetn=0):
  - All entries invalid, addresses 0.
  - State ARMED.
  - o_breakpointHitN=1, o_hitIdx=0, o_hitCount=0.
- Table write:
  - On i_bpWrEn, entry[i_bpIdx] <= {i_bpValid, i_bpAddr}, effective the next cycle.
  - A write and a match in the same cycle: the match uses the old table contents.
  - i_bpIdx >= NUM_BP: write ignored.
- Match (combinational):
  - Entry k matches when valid[k] and addr[k]==i_pc.
  - Several matches: the lowest index wins.
- State machine: ARMED, HIT, SKIP.
  - ARMED: if i_breakpointEnableN=0, i_instrStart=1 and any match -> HIT; o_hitIdx <= winning index; o_breakpointHitN goes 0 one cycle after the i_instrStart sample (registered output).
  - HIT:
    - o_breakpointHitN held 0.
    - i_continue=1 -> SKIP; o_breakpointHitN=1 from the next cycle.
    - i_breakpointEnableN=1 -> ARMED immediately, hit released.
    - Continue and disable in the same cycle -> ARMED.
  - SKIP: matches suppressed. When i_ctrlInstrFinishedN=0 -> ARMED. A finish in the same cycle as a new i_instrStart is evaluated as ARMED, so the next instruction can hit.
- i_continue outside HIT: ignored.
- Clearing or rewriting the hit entry while in HIT does not release the hit; only continue, disable or reset does.
- i_instrStart during HIT: ignored (the core is halted; spurious pulses must not change o_hitIdx).
- Reset mid-HIT: immediate release, table cleared.
- No latency beyond one register stage; no backpressure.

Optional Feature:
- Macro: BREAKPOINT_HIT_COUNT_EN.
- Defined: o_hitCount increments by 1 on every ARMED->HIT transition, saturates at 255, and clears only on reset.
- Not defined: no counter register; o_hitCount is tied to 0.

Test Plan:
- Basic hit: reset; write idx0=0x0040 valid; enable (i_breakpointEnableN=0); pulse i_instrStart with i_pc=0x0040 -> o_breakpointHitN=0 the next cycle, o_hitIdx=0; remains 0 for 20 cycles without continue.
- Continue/skip: from the hit, pulse i_continue -> hit=1 the next cycle; i_instrStart with pc 0x0040 again before i_ctrlInstrFinishedN=0 -> no hit; after finish, i_instrStart with pc 0x0040 -> hit=0.
- Priority and clear: idx1=0x0100, idx3=0x0100 valid -> hit with o_hitIdx=1; clear idx1, continue, finish, start at 0x0100 -> o_hitIdx=3.
- Disable: breakpoint set and i_breakpointEnableN=1, pc matches -> never hits; assert disable while in HIT -> hit released the next cycle.
- Write collision and reset: write idx2=0x0200 in the same cycle as i_instrStart pc=0x0200 -> no hit; repeat one cycle later -> hit. Assert i_resetn=0 during the hit -> o_breakpointHitN=1 asynchronously and all entries invalid.
- Counter (BREAKPOINT_HIT_COUNT_EN): 300 hit/continue/finish cycles -> o_hitCount=255. Without the macro -> o_hitCount stays 0.
